ni_link_out_retx_buffer: RTL and testbench

//  NI-side output stage between axi_ni_request and the outgoing NoC link.

---
 rtl/ni_link_out_retx_buffer.sv | 140 ++++++++++++++
 tb/tb_ni_link_out_retx_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ni_link_out_retx_buffer.sv
// NI output stage: circular store of request flits with registered link launch,
// in-order ACK retirement and go-back-N rewind on NACK; BWDAUX3_in stalls new launches.
module ni_link_out_retx_buffer #(
    parameter int FLIT_WIDTH           = 80,
    parameter int OUT_BUFFER_DEPTH     = 6,
    parameter int LOG_OUT_BUFFER_DEPTH = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [FLIT_WIDTH-1:0]         data_in,
    input  logic                          tail_in,
    input  logic                          write,
    output logic                          full,
    output logic [FLIT_WIDTH-1:0]         FLIT_out,
    output logic                          VALID_out,
    output logic                          FWDAUX1_out,
    input  logic                          BWDAUX1_in,
    input  logic                          BWDAUX2_in,
    input  logic                          BWDAUX3_in,
    output logic [LOG_OUT_BUFFER_DEPTH:0] occupancy,
    output logic                          idle
);

    localparam int PW = LOG_OUT_BUFFER_DEPTH;
    localparam int CW = LOG_OUT_BUFFER_DEPTH + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    // Depth need not be a power of two, so wrap explicitly instead of relying on overflow.
    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_inc = (p == PW'(OUT_BUFFER_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [FLIT_WIDTH:0]   mem_q [OUT_BUFFER_DEPTH];

    ptr_t                  wr_ptr_q,   wr_ptr_d;
    ptr_t                  snd_ptr_q,  snd_ptr_d;
    ptr_t                  ack_ptr_q,  ack_ptr_d;
    cnt_t                  held_q,     held_d;
    cnt_t                  inflight_q, inflight_d;
    logic                  valid_q,    valid_d;
    logic                  tail_q,     tail_d;
    logic [FLIT_WIDTH-1:0] flit_q,     flit_d;

    logic do_write;
    logic do_ack;
    logic do_nack;
    logic do_launch;

    assign full     = (held_q == CW'(OUT_BUFFER_DEPTH));
    assign do_write = write && !full;
    assign do_nack  = BWDAUX2_in;
    assign do_ack   = BWDAUX1_in && !BWDAUX2_in && (inflight_q != '0);
    // held >= inflight always, so "pend > 0" is simply held != inflight.
    assign do_launch = (held_q != inflight_q) && !BWDAUX3_in && !BWDAUX2_in;

    // NOTE: combinational next-state uses blocking '=' with a default for every
    // signal first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        snd_ptr_d  = snd_ptr_q;
        ack_ptr_d  = ack_ptr_q;
        held_d     = held_q;
        inflight_d = inflight_q;
        valid_d    = 1'b0;
        tail_d     = 1'b0;
        flit_d     = flit_q;

        if (do_write) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end

        if (do_write && !do_ack) begin
            held_d = held_q + 1'b1;
        end else if (!do_write && do_ack) begin
            held_d = held_q - 1'b1;
        end

        if (do_launch) begin
            valid_d          = 1'b1;
            {tail_d, flit_d} = mem_q[snd_ptr_q];
        end

        if (do_nack) begin
            snd_ptr_d  = ack_ptr_q;
            inflight_d = '0;
        end else begin
            if (do_launch) begin
                snd_ptr_d = ptr_inc(snd_ptr_q);
            end
            if (do_ack) begin
                ack_ptr_d = ptr_inc(ack_ptr_q);
            end
            if (do_launch && !do_ack) begin
                inflight_d = inflight_q + 1'b1;
            end else if (!do_launch && do_ack) begin
                inflight_d = inflight_q - 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            snd_ptr_q  <= '0;
            ack_ptr_q  <= '0;
            held_q     <= '0;
            inflight_q <= '0;
            valid_q    <= 1'b0;
            tail_q     <= 1'b0;
            flit_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            snd_ptr_q  <= snd_ptr_d;
            ack_ptr_q  <= ack_ptr_d;
            held_q     <= held_d;
            inflight_q <= inflight_d;
            valid_q    <= valid_d;
            tail_q     <= tail_d;
            flit_q     <= flit_d;
        end
    end

    // NOTE: the store is deliberately not reset; an entry is only read after it has
    // been written, since the counters gate every launch.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= {tail_in, data_in};
        end
    end

    assign FLIT_out    = flit_q;
    assign VALID_out   = valid_q;
    assign FWDAUX1_out = tail_q;
    assign occupancy   = held_q;
    assign idle        = (held_q == '0);

endmodule

// File: tb/tb_ni_link_out_retx_buffer.sv
// Self-checking bench for ni_link_out_retx_buffer: a queue-based model of the un-ACKed
// flits is compared with the DUT outputs after every clock edge.
module tb_ni_link_out_retx_buffer;

    localparam int FW    = 80;
    localparam int DEPTH = 6;
    localparam int LOGD  = 3;

    logic          clk;
    logic          rst;
    logic [FW-1:0] data_in;
    logic          tail_in;
    logic          write;
    logic          full;
    logic [FW-1:0] FLIT_out;
    logic          VALID_out;
    logic          FWDAUX1_out;
    logic          BWDAUX1_in;
    logic          BWDAUX2_in;
    logic          BWDAUX3_in;
    logic [LOGD:0] occupancy;
    logic          idle;

    ni_link_out_retx_buffer #(
        .FLIT_WIDTH          (FW),
        .OUT_BUFFER_DEPTH    (DEPTH),
        .LOG_OUT_BUFFER_DEPTH(LOGD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .tail_in    (tail_in),
        .write      (write),
        .full       (full),
        .FLIT_out   (FLIT_out),
        .VALID_out  (VALID_out),
        .FWDAUX1_out(FWDAUX1_out),
        .BWDAUX1_in (BWDAUX1_in),
        .BWDAUX2_in (BWDAUX2_in),
        .BWDAUX3_in (BWDAUX3_in),
        .occupancy  (occupancy),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model: queue of un-ACKed flits (oldest first) and how many of them are in flight.
    logic [FW:0]   m_q[$];
    int            m_inflight = 0;
    logic          m_valid    = 1'b0;
    logic          m_tail     = 1'b0;
    logic [FW-1:0] m_flit     = '0;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_inflight = 0;
        m_valid    = 1'b0;
        m_tail     = 1'b0;
        m_flit     = '0;
    endtask

    task automatic model_edge(input logic w, input logic [FW-1:0] d, input logic t,
                              input logic a, input logic n, input logic s);
        int   pend;
        logic was_full;
        logic ak;
        logic ln;
        pend     = m_q.size() - m_inflight;
        was_full = (m_q.size() == DEPTH);
        ak       = a && !n && (m_inflight > 0);
        ln       = (pend > 0) && !s && !n;
        if (ln) begin
            m_valid          = 1'b1;
            {m_tail, m_flit} = m_q[m_inflight];
        end else begin
            m_valid = 1'b0;
            m_tail  = 1'b0;
        end
        if (n) begin
            m_inflight = 0;
        end else begin
            if (ln) m_inflight++;
            if (ak) begin
                void'(m_q.pop_front());
                m_inflight--;
            end
        end
        if (w && !was_full) m_q.push_back({t, d});
    endtask

    task automatic check_outputs();
        check("valid",     FW'(VALID_out),   FW'(m_valid));
        check("tail",      FW'(FWDAUX1_out), FW'(m_tail));
        check("flit",      FLIT_out,         m_flit);
        check("occupancy", FW'(occupancy),   FW'(m_q.size()));
        check("idle",      FW'(idle),        FW'(m_q.size() == 0));
        check("full",      FW'(full),        FW'(m_q.size() == DEPTH));
    endtask

    function automatic logic [FW-1:0] rand_flit();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    // Drive one cycle of inputs, clock it, update the model, then compare off the edge.
    task automatic step(input logic w, input logic [FW-1:0] d, input logic t,
                        input logic a, input logic n, input logic s);
        write      = w;
        data_in    = d;
        tail_in    = t;
        BWDAUX1_in = a;
        BWDAUX2_in = n;
        BWDAUX3_in = s;
        @(posedge clk);
        model_edge(w, d, t, a, n, s);
        #1;
        check_outputs();
    endtask

    task automatic idle_step();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ACK whatever is in flight until the store empties, within a cycle budget.
    task automatic drain(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (m_q.size() == 0) break;
            step(1'b0, '0, 1'b0, m_inflight > 0, 1'b0, 1'b0);
        end
        check(tag, FW'(idle), FW'(1'b1));
    endtask

    initial begin
        logic [8:0] vmask;
        int         nvalid;

        rst        = 1'b0;
        write      = 1'b0;
        data_in    = '0;
        tail_in    = 1'b0;
        BWDAUX1_in = 1'b0;
        BWDAUX2_in = 1'b0;
        BWDAUX3_in = 1'b0;
        model_reset();
        #12;
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b1;

        // 1: three flits, ACK each two cycles after it appears.
        vmask = '0;
        for (int i = 0; i < 9; i++) begin
            step(i < 3, rand_flit(), i == 2, (i >= 4) && (i <= 6), 1'b0, 1'b0);
            vmask[i] = VALID_out;
        end
        check("t1_valid_cycles", FW'(vmask), FW'(9'b0_0000_1110));
        check("t1_idle", FW'(idle), FW'(1'b1));

        // 2: fill under stall, seventh write dropped, then release.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, rand_flit(), i == 6, 1'b0, 1'b0, 1'b1);
            if (i == 5) check("t2_full_after_6", FW'(full), FW'(1'b1));
        end
        check("t2_occ", FW'(occupancy), FW'(6));
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            idle_step();
            if (VALID_out) nvalid++;
        end
        check("t2_sent", FW'(nvalid), FW'(6));
        drain("t2_drain");

        // 3: B1..B4, ACK B1, NACK B2 -> gap then B2..B4 resent.
        for (int i = 0; i < 6; i++) step(i < 4, rand_flit(), i == 3, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_nack_gap", FW'(VALID_out), FW'(1'b0));
        check("t3_occ", FW'(occupancy), FW'(3));
        for (int i = 0; i < 4; i++) idle_step();
        check("t3_occ_held", FW'(occupancy), FW'(3));
        drain("t3_drain");

        // 4: ACK and NACK together with two in flight.
        for (int i = 0; i < 4; i++) step(i < 2, rand_flit(), i == 1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t4_occ", FW'(occupancy), FW'(2));
        drain("t4_drain");

        // 5: write while full with a same-cycle ACK.
        for (int i = 0; i < 6; i++) step(1'b1, rand_flit(), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, rand_flit(), 1'b1, 1'b1, 1'b0, 1'b0);
        check("t5_occ", FW'(occupancy), FW'(5));
        check("t5_full", FW'(full), FW'(1'b0));
        drain("t5_drain");

        // Randomized traffic with stalls, ACKs (some spurious) and occasional NACKs.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 3) != 0, rand_flit(), ($urandom % 4) == 0,
                 ($urandom % 2) == 0, (($urandom % 13) == 0) && (m_inflight > 0),
                 ($urandom % 5) == 0);
        end

        // 6: asynchronous reset mid-burst.
        for (int i = 0; i < 5; i++) step(1'b1, rand_flit(), 1'b0, 1'b0, 1'b0, 1'b0);
        write = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("t6_valid", FW'(VALID_out), FW'(1'b0));
        check("t6_tail", FW'(FWDAUX1_out), FW'(1'b0));
        check("t6_flit", FLIT_out, '0);
        check("t6_idle", FW'(idle), FW'(1'b1));
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 6; i++) idle_step();
        for (int i = 0; i < 3; i++) step(1'b1, rand_flit(), i == 2, 1'b0, 1'b0, 1'b0);
        drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
